// File: rtl/wts_key_event_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// wts_key_sched_pkg
// Shared types for the key event scheduler: command codes written by the CPU,
// per-channel note states, the three-bit key pulse bundle and a small decode
// helper used by the top level.
// Configuration macro: WTS_HARD_RESTART_EN (consumed in wts_key_sched_channel).
// -----------------------------------------------------------------------------
package wts_key_sched_pkg;

  localparam int CH_NUM_MAX = 8;

  typedef enum logic [1:0] {
    CMD_NONE    = 2'd0,
    CMD_KEY_ON  = 2'd1,
    CMD_RELEASE = 2'd2,
    CMD_OFF     = 2'd3
  } key_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SOUND   = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RESTART = 2'd3
  } ch_state_t;

  typedef struct packed {
    logic key_on;
    logic key_release;
    logic key_off;
  } key_pulse_t;

  localparam key_pulse_t PULSE_NONE = 3'b000;

  // True when a bus write carries a real command aimed at channel idx.
  // Channels at or above CH_NUM never match because no channel with that
  // index is instantiated.
  function automatic logic cmd_write_hit(input logic       wr,
                                         input logic [2:0] ch,
                                         input logic [1:0] cmd,
                                         input logic [2:0] idx);
    return wr && (cmd != 2'(CMD_NONE)) && (ch == idx);
  endfunction

endpackage

// File: rtl/wts_key_event_scheduler_if.sv
// -----------------------------------------------------------------------------
// wts_key_event_scheduler_if
// CPU-side command bus of the key event scheduler.
//   bus_wr  : one-clock write strobe
//   bus_ch  : target channel number
//   bus_cmd : command code (00 none, 01 KEY_ON, 10 RELEASE, 11 OFF)
// Modports: master = register bus driver, slave = scheduler.
// -----------------------------------------------------------------------------
interface wts_key_event_scheduler_if;

  logic       bus_wr;
  logic [2:0] bus_ch;
  logic [1:0] bus_cmd;

  modport master (
    output bus_wr,
    output bus_ch,
    output bus_cmd
  );

  modport slave (
    input bus_wr,
    input bus_ch,
    input bus_cmd
  );

endinterface

// File: rtl/wts_key_event_scheduler_channel.sv
// -----------------------------------------------------------------------------
// wts_key_sched_channel
// One scheduler channel: pending command slot, note-state FSM and the three
// registered key pulse outputs feeding one envelope generator.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   active       : decision strobe (one clock in six)
//   wr_en        : a valid command is written to this channel this clock
//   wr_cmd       : the command being written
//   env_zero     : generator envelope has reached zero
//   key_on / key_release / key_off : pulses, held for one whole period
//   ch_state     : current note state
// Configuration: WTS_HARD_RESTART_EN makes a re-trigger from SOUND/RELEASE
// go through key_off + RESTART before the new key_on.
// -----------------------------------------------------------------------------
module wts_key_sched_channel
  import wts_key_sched_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       active,
  input  logic       wr_en,
  input  logic [1:0] wr_cmd,
  input  logic       env_zero,
  output logic       key_on,
  output logic       key_release,
  output logic       key_off,
  output logic [1:0] ch_state
);

  ch_state_t  state_r;
  ch_state_t  state_nxt_s;
  key_cmd_t   slot_r;
  key_cmd_t   slot_nxt_s;
  key_pulse_t pulse_r;
  key_pulse_t pulse_nxt_s;
  logic       consume_s;

  // Decision logic: what this channel would do if the current edge is a
  // decision edge. Only applied to state/outputs when active is high.
  always_comb begin
    state_nxt_s = state_r;
    pulse_nxt_s = PULSE_NONE;
    consume_s   = 1'b0;
    if (state_r == ST_RESTART) begin
      // The second half of a hard restart ignores the slot, except that a
      // pending OFF cancels the pending key_on outright.
      if (slot_r == CMD_OFF) begin
        state_nxt_s = ST_IDLE;
        consume_s   = 1'b1;
      end else begin
        pulse_nxt_s.key_on = 1'b1;
        state_nxt_s        = ST_SOUND;
      end
    end else begin
      case (slot_r)
        CMD_KEY_ON: begin
          consume_s = 1'b1;
          if (state_r == ST_IDLE) begin
            pulse_nxt_s.key_on = 1'b1;
            state_nxt_s        = ST_SOUND;
          end else begin
`ifdef WTS_HARD_RESTART_EN
            pulse_nxt_s.key_off = 1'b1;
            state_nxt_s         = ST_RESTART;
`else
            pulse_nxt_s.key_on = 1'b1;
            state_nxt_s        = ST_SOUND;
`endif
          end
        end
        CMD_RELEASE: begin
          consume_s = 1'b1;
          if (state_r == ST_SOUND) begin
            pulse_nxt_s.key_release = 1'b1;
            state_nxt_s             = ST_RELEASE;
          end else begin
            state_nxt_s = state_r;
          end
        end
        CMD_OFF: begin
          consume_s = 1'b1;
          if ((state_r == ST_SOUND) || (state_r == ST_RELEASE)) begin
            pulse_nxt_s.key_off = 1'b1;
            state_nxt_s         = ST_IDLE;
          end else begin
            state_nxt_s = state_r;
          end
        end
        CMD_NONE: begin
          // Auto-off once a released note has decayed to silence.
          if ((state_r == ST_RELEASE) && env_zero) begin
            pulse_nxt_s.key_off = 1'b1;
            state_nxt_s         = ST_IDLE;
          end else begin
            state_nxt_s = state_r;
          end
        end
        default: begin
          state_nxt_s = state_r;
        end
      endcase
    end
  end

  // Slot next value: a write in the same clock beats consumption, so a
  // command landing on a decision edge survives for the next period.
  always_comb begin
    slot_nxt_s = slot_r;
    if (wr_en) begin
      slot_nxt_s = key_cmd_t'(wr_cmd);
    end else if (active && consume_s) begin
      slot_nxt_s = CMD_NONE;
    end else begin
      slot_nxt_s = slot_r;
    end
  end

  // Pending command slot register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_r <= CMD_NONE;
    end else begin
      slot_r <= slot_nxt_s;
    end
  end

  // Note-state register, advanced only at decision edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else if (active) begin
      state_r <= state_nxt_s;
    end else begin
      state_r <= state_r;
    end
  end

  // Pulse registers: reloaded at every decision edge so a pulse lasts
  // exactly one period and the generator sees it on one active clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pulse_r <= PULSE_NONE;
    end else if (active) begin
      pulse_r <= pulse_nxt_s;
    end else begin
      pulse_r <= pulse_r;
    end
  end

  assign key_on      = pulse_r.key_on;
  assign key_release = pulse_r.key_release;
  assign key_off     = pulse_r.key_off;
  assign ch_state    = state_r;

endmodule

// File: rtl/wts_key_event_scheduler.sv
// -----------------------------------------------------------------------------
// wts_key_event_scheduler
// Per-channel key event scheduler between the CPU register bus and the bank
// of envelope generators. Decodes the target channel of each bus write and
// packs the per-channel outputs; all behaviour lives in wts_key_sched_channel.
// Parameters:
//   CH_NUM      : number of channels, 1..8
// Ports:
//   clk, reset  : 21.477 MHz clock, asynchronous active-high reset
//   active      : decision strobe, one clock in six
//   bus         : command bus (bus_wr, bus_ch, bus_cmd), slave side
//   env_zero    : per-channel envelope-is-zero flags
//   key_on, key_release, key_off : per-channel pulses to the generators
//   ch_state    : per-channel note state, channel n at [2n+1:2n]
// Configuration macro: WTS_HARD_RESTART_EN (hard restart on re-trigger).
// -----------------------------------------------------------------------------
module wts_key_event_scheduler
  import wts_key_sched_pkg::*;
#(
  parameter int CH_NUM = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    active,
  wts_key_event_scheduler_if.slave bus,
  input  logic [CH_NUM-1:0]       env_zero,
  output logic [CH_NUM-1:0]       key_on,
  output logic [CH_NUM-1:0]       key_release,
  output logic [CH_NUM-1:0]       key_off,
  output logic [2*CH_NUM-1:0]     ch_state
);

  logic [CH_NUM-1:0] wr_sel_s;

  // Channel decode: one-hot write enable per instantiated channel.
  always_comb begin
    wr_sel_s = '0;
    for (int n = 0; n < CH_NUM; n++) begin
      wr_sel_s[n] = cmd_write_hit(bus.bus_wr, bus.bus_ch, bus.bus_cmd, 3'(n));
    end
  end

  for (genvar n = 0; n < CH_NUM; n++) begin : g_ch
    wts_key_sched_channel u_ch (
      .clk         (clk),
      .reset       (reset),
      .active      (active),
      .wr_en       (wr_sel_s[n]),
      .wr_cmd      (bus.bus_cmd),
      .env_zero    (env_zero[n]),
      .key_on      (key_on[n]),
      .key_release (key_release[n]),
      .key_off     (key_off[n]),
      .ch_state    (ch_state[2*n+1:2*n])
    );
  end

endmodule

// File: tb/tb_wts_key_event_scheduler.sv
// -----------------------------------------------------------------------------
// tb_wts_key_event_scheduler
// Self-checking bench for wts_key_event_scheduler with CH_NUM = 5. A per-channel
// reference model of slots and note states is stepped at every clock edge.
// Honours WTS_HARD_RESTART_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_wts_key_event_scheduler;

  localparam int CH = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            active;
  logic [CH-1:0]   env_zero;
  logic [CH-1:0]   key_on;
  logic [CH-1:0]   key_release;
  logic [CH-1:0]   key_off;
  logic [2*CH-1:0] ch_state;

  wts_key_event_scheduler_if bus_if ();

  wts_key_event_scheduler #(.CH_NUM(CH)) dut (
    .clk         (clk),
    .reset       (reset),
    .active      (active),
    .bus         (bus_if),
    .env_zero    (env_zero),
    .key_on      (key_on),
    .key_release (key_release),
    .key_off     (key_off),
    .ch_state    (ch_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int phase  = 0;
  logic last_act = 1'b0;

  // reference model: slot 0 = empty, 1 KEY_ON, 2 RELEASE, 3 OFF;
  // state 0 IDLE, 1 SOUND, 2 RELEASE, 3 RESTART
  int            m_slot  [CH];
  int            m_state [CH];
  logic [CH-1:0] m_on, m_rel, m_off;

  function automatic logic [2*CH-1:0] m_state_vec();
    logic [2*CH-1:0] v = '0;
    for (int n = 0; n < CH; n++) v[2*n +: 2] = 2'(m_state[n]);
    return v;
  endfunction

  function automatic void model_edge(logic rst, logic wr, logic [2:0] ch,
                                     logic [1:0] cmd, logic act, logic [CH-1:0] ez);
    if (rst) begin
      for (int n = 0; n < CH; n++) begin m_slot[n] = 0; m_state[n] = 0; end
      m_on = '0; m_rel = '0; m_off = '0;
      return;
    end
    for (int n = 0; n < CH; n++) begin
      if (act) begin
        m_on[n] = 1'b0; m_rel[n] = 1'b0; m_off[n] = 1'b0;
        if (m_state[n] == 3) begin
          if (m_slot[n] == 3) begin m_state[n] = 0; m_slot[n] = 0; end
          else begin m_on[n] = 1'b1; m_state[n] = 1; end
        end else if (m_slot[n] == 1) begin
          if (m_state[n] == 0) begin m_on[n] = 1'b1; m_state[n] = 1; end
          else begin
`ifdef WTS_HARD_RESTART_EN
            m_off[n] = 1'b1; m_state[n] = 3;
`else
            m_on[n] = 1'b1; m_state[n] = 1;
`endif
          end
          m_slot[n] = 0;
        end else if (m_slot[n] == 2) begin
          if (m_state[n] == 1) begin m_rel[n] = 1'b1; m_state[n] = 2; end
          m_slot[n] = 0;
        end else if (m_slot[n] == 3) begin
          if (m_state[n] == 1 || m_state[n] == 2) begin m_off[n] = 1'b1; m_state[n] = 0; end
          m_slot[n] = 0;
        end else if (m_state[n] == 2 && ez[n]) begin
          m_off[n] = 1'b1; m_state[n] = 0;
        end
      end
      if (wr && cmd != 2'd0 && int'(ch) == n) m_slot[n] = int'(cmd);
    end
  endfunction

  // One clock: drive inputs, take the edge, step the model, settle.
  task automatic cycle(input logic wr, input logic [2:0] ch, input logic [1:0] cmd);
    bus_if.bus_wr  = wr;
    bus_if.bus_ch  = ch;
    bus_if.bus_cmd = cmd;
    active = (phase == 5);
    @(posedge clk);
    model_edge(reset, wr, ch, cmd, active, env_zero);
    last_act = active;
    phase = (phase + 1) % 6;
    #1;
    bus_if.bus_wr  = 1'b0;
    bus_if.bus_cmd = 2'd0;
    active = 1'b0;
  endtask

  task automatic wait_decision();
    do cycle(1'b0, 3'd0, 2'd0); while (!last_act);
  endtask

  task automatic apply_reset();
    env_zero = '0;
    reset = 1'b1;
    cycle(1'b0, 3'd0, 2'd0);
    cycle(1'b0, 3'd0, 2'd0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({key_on, key_release, key_off} !== '0 || ch_state !== '0) begin
      errors++;
      $display("FAIL reset_values on=%b rel=%b off=%b st=%b, required all 0",
               key_on, key_release, key_off, ch_state);
    end
    for (int i = 0; i < 300; i++) begin
      env_zero = CH'($urandom);
      cycle(1'b1, 3'($urandom_range(0, 7)), 2'd0);
      if (last_act) begin
        checks++;
        if ({key_on, key_release, key_off} !== '0 || ch_state !== '0) begin
          errors++;
          $display("FAIL reset_idle cyc=%0d on=%b rel=%b off=%b st=%b, required all 0",
                   i, key_on, key_release, key_off, ch_state);
        end
      end
    end
    env_zero = '0;
    wait_decision();
    cycle(1'b1, 3'd0, 2'd1);
    wait_decision();
    checks++;
    if (key_on !== 5'b00001) begin
      errors++;
      $display("FAIL pre_reset_pulse key_on=%b, required 00001", key_on);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (key_on !== '0 || ch_state !== '0) begin
      errors++;
      $display("FAIL reset_mid_pulse key_on=%b st=%b, required 0", key_on, ch_state);
    end
    model_edge(1'b1, 1'b0, 3'd0, 2'd0, 1'b0, env_zero);
    cycle(1'b0, 3'd0, 2'd0);
    reset = 1'b0;
  endtask

  task automatic test_key_on_idle();
    apply_reset();
    wait_decision();
    cycle(1'b1, 3'd2, 2'd1);
    wait_decision();
    checks++;
    if (key_on !== 5'b00100 || key_release !== '0 || key_off !== '0 || ch_state[5:4] !== 2'd1) begin
      errors++;
      $display("FAIL key_on_idle on=%b rel=%b off=%b st2=%0d, required on=00100 st2=1",
               key_on, key_release, key_off, ch_state[5:4]);
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 3'd0, 2'd0);
      checks++;
      if (key_on !== 5'b00100) begin
        errors++;
        $display("FAIL key_on_hold cyc=%0d key_on=%b, required 00100", i, key_on);
      end
    end
    cycle(1'b0, 3'd0, 2'd0);
    checks++;
    if (!last_act || key_on !== '0 || ch_state !== 10'b00_00_01_00_00) begin
      errors++;
      $display("FAIL key_on_end act=%b key_on=%b st=%b, required 1/00000/0000010000",
               last_act, key_on, ch_state);
    end
  endtask

  task automatic test_release_autooff();
    apply_reset();
    wait_decision();
    cycle(1'b1, 3'd0, 2'd1);
    wait_decision();
    wait_decision();
    cycle(1'b1, 3'd0, 2'd2);
    wait_decision();
    checks++;
    if (key_release !== 5'b00001 || key_off !== '0 || ch_state[1:0] !== 2'd2) begin
      errors++;
      $display("FAIL release rel=%b off=%b st0=%0d, required 00001/00000/2",
               key_release, key_off, ch_state[1:0]);
    end
    wait_decision();
    checks++;
    if (key_off !== '0 || ch_state[1:0] !== 2'd2) begin
      errors++;
      $display("FAIL release_hold off=%b st0=%0d, required 00000/2", key_off, ch_state[1:0]);
    end
    env_zero[0] = 1'b1;
    wait_decision();
    checks++;
    if (key_off !== 5'b00001 || key_release !== '0 || ch_state[1:0] !== 2'd0) begin
      errors++;
      $display("FAIL auto_off off=%b rel=%b st0=%0d, required 00001/00000/0",
               key_off, key_release, ch_state[1:0]);
    end
    wait_decision();
    checks++;
    if (key_off !== '0) begin
      errors++;
      $display("FAIL auto_off_end off=%b, required 00000", key_off);
    end
    env_zero = '0;
  endtask

  task automatic test_retrigger();
    apply_reset();
    wait_decision();
    cycle(1'b1, 3'd1, 2'd1);
    wait_decision();
    wait_decision();
    cycle(1'b1, 3'd1, 2'd1);
    wait_decision();
`ifdef WTS_HARD_RESTART_EN
    checks++;
    if (key_off !== 5'b00010 || key_on !== '0 || ch_state[3:2] !== 2'd3) begin
      errors++;
      $display("FAIL retrig_k off=%b on=%b st1=%0d, required 00010/00000/3",
               key_off, key_on, ch_state[3:2]);
    end
    wait_decision();
    checks++;
    if (key_on !== 5'b00010 || key_off !== '0 || ch_state[3:2] !== 2'd1) begin
      errors++;
      $display("FAIL retrig_k1 on=%b off=%b st1=%0d, required 00010/00000/1",
               key_on, key_off, ch_state[3:2]);
    end
`else
    checks++;
    if (key_on !== 5'b00010 || key_off !== '0 || ch_state[3:2] !== 2'd1) begin
      errors++;
      $display("FAIL retrig on=%b off=%b st1=%0d, required 00010/00000/1",
               key_on, key_off, ch_state[3:2]);
    end
    wait_decision();
    checks++;
    if (key_on !== '0 || key_off !== '0 || ch_state[3:2] !== 2'd1) begin
      errors++;
      $display("FAIL retrig_k1 on=%b off=%b st1=%0d, required 00000/00000/1",
               key_on, key_off, ch_state[3:2]);
    end
`endif
  endtask

  task automatic test_overwrite_coincident();
    apply_reset();
    wait_decision();
    cycle(1'b1, 3'd3, 2'd1);
    cycle(1'b1, 3'd3, 2'd3);
    wait_decision();
    checks++;
    if (key_on !== '0 || key_off !== '0 || ch_state !== '0) begin
      errors++;
      $display("FAIL overwrite on=%b off=%b st=%b, required all 0", key_on, key_off, ch_state);
    end
    // KEY_ON written exactly on a decision edge
    for (int i = 0; i < 5; i++) cycle(1'b0, 3'd0, 2'd0);
    cycle(1'b1, 3'd4, 2'd1);
    checks++;
    if (!last_act || key_on !== '0 || ch_state !== '0) begin
      errors++;
      $display("FAIL coincident_now act=%b on=%b st=%b, required 1/00000/0", last_act, key_on, ch_state);
    end
    wait_decision();
    checks++;
    if (key_on !== 5'b10000 || ch_state[9:8] !== 2'd1) begin
      errors++;
      $display("FAIL coincident_next on=%b st4=%0d, required 10000/1", key_on, ch_state[9:8]);
    end
    // coincident write replaces the slot being consumed on that edge
    cycle(1'b1, 3'd4, 2'd2);
    for (int i = 0; i < 4; i++) cycle(1'b0, 3'd0, 2'd0);
    cycle(1'b1, 3'd4, 2'd3);
    checks++;
    if (key_release !== 5'b10000 || ch_state[9:8] !== 2'd2) begin
      errors++;
      $display("FAIL coincident_consume rel=%b st4=%0d, required 10000/2", key_release, ch_state[9:8]);
    end
    wait_decision();
    checks++;
    if (key_off !== 5'b10000 || ch_state[9:8] !== 2'd0) begin
      errors++;
      $display("FAIL coincident_wins off=%b st4=%0d, required 10000/0", key_off, ch_state[9:8]);
    end
  endtask

  task automatic test_invalid();
    apply_reset();
    wait_decision();
    cycle(1'b1, 3'd7, 2'd1);
    cycle(1'b1, 3'd5, 2'd1);
    cycle(1'b1, 3'd0, 2'd0);
    wait_decision();
    checks++;
    if ({key_on, key_release, key_off} !== '0 || ch_state !== '0) begin
      errors++;
      $display("FAIL invalid_ch on=%b rel=%b off=%b st=%b, required all 0",
               key_on, key_release, key_off, ch_state);
    end
    cycle(1'b1, 3'd1, 2'd2);
    cycle(1'b1, 3'd2, 2'd3);
    wait_decision();
    checks++;
    if ({key_on, key_release, key_off} !== '0 || ch_state !== '0) begin
      errors++;
      $display("FAIL idle_rel_off on=%b rel=%b off=%b st=%b, required all 0",
               key_on, key_release, key_off, ch_state);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) env_zero = CH'($urandom);
      cycle($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
      checks++;
      if (key_on !== m_on || key_release !== m_rel || key_off !== m_off || ch_state !== m_state_vec()) begin
        errors++;
        $display("FAIL random cyc=%0d on=%b/%b rel=%b/%b off=%b/%b st=%b/%b (actual/required)",
                 i, key_on, m_on, key_release, m_rel, key_off, m_off, ch_state, m_state_vec());
      end
      checks++;
      if (((key_on & key_release) | (key_on & key_off) | (key_release & key_off)) !== '0) begin
        errors++;
        $display("FAIL exclusive cyc=%0d on=%b rel=%b off=%b, required disjoint",
                 i, key_on, key_release, key_off);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    active = 1'b0;
    env_zero = '0;
    bus_if.bus_wr = 1'b0;
    bus_if.bus_ch = 3'd0;
    bus_if.bus_cmd = 2'd0;
    test_reset();
    test_key_on_idle();
    test_release_autooff();
    test_retrigger();
    test_overwrite_coincident();
    test_invalid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
